// File: rtl/tmds_rx_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_rx_channel
//  Purpose  : Single TMDS receive channel. Deserialises a 1-bit TMDS stream
//             (LSB first), finds 10-bit word alignment by hunting for control
//             tokens, confirms it over LOCK_COUNT aligned tokens, then decodes
//             every aligned word into either a control token or a pixel byte.
//             Alignment is dropped after TIMEOUT_WORDS consecutive data words.
//  Ports    : tmds_clk   - bit clock, one TMDS bit per rising edge
//             resetn     - asynchronous active-low reset
//             in_tmds    - serial TMDS bit, synchronous to tmds_clk
//             out_valid  - one-cycle strobe for each decoded word
//             out_de     - 1 = data word, 0 = control token
//             out_data   - decoded pixel byte (0 for tokens)
//             out_c      - control bits {c1,c0} of the last token
//             out_locked - high while word alignment is held
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_rx_channel #(
    parameter int LOCK_COUNT    = 8,
    parameter int TIMEOUT_WORDS = 4096
) (
    input  logic       tmds_clk,
    input  logic       resetn,
    input  logic       in_tmds,
    output logic       out_valid,
    output logic       out_de,
    output logic [7:0] out_data,
    output logic [1:0] out_c,
    output logic       out_locked
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int TO_W    = $clog2(TIMEOUT_WORDS + 1);

    localparam logic [MATCH_W-1:0] LOCK_COUNT_C    = MATCH_W'(LOCK_COUNT);
    localparam logic [TO_W-1:0]    TIMEOUT_WORDS_C = TO_W'(TIMEOUT_WORDS);
    localparam logic [3:0]         PHASE_LAST      = 4'd9;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [9:0]         sr_q,         sr_d;
    logic [3:0]         phase_q,      phase_d;
    logic [MATCH_W-1:0] match_cnt_q,  match_cnt_d;
    logic [TO_W-1:0]    timeout_q,    timeout_d;
    logic               out_valid_q,  out_valid_d;
    logic               out_de_q,     out_de_d;
    logic [7:0]         out_data_q,   out_data_d;
    logic [1:0]         out_c_q,      out_c_d;
    logic               out_locked_q, out_locked_d;

    logic               is_token;
    logic [1:0]         token_c;
    logic [7:0]         q_inv;
    logic [7:0]         dec_data;
    logic               boundary;
    logic [MATCH_W-1:0] match_inc;
    logic [TO_W-1:0]    timeout_inc;

    assign boundary    = (phase_q == PHASE_LAST);
    assign match_inc   = match_cnt_q + MATCH_W'(1);
    assign timeout_inc = timeout_q + TO_W'(1);

    // Control token recognition on the current shift-register contents.
    always_comb begin
        is_token = 1'b1;
        token_c  = 2'b00;
        case (sr_q)
            10'h354: token_c = 2'b00;
            10'h0AB: token_c = 2'b01;
            10'h154: token_c = 2'b10;
            10'h2AB: token_c = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    // TMDS data decode: undo the optional inversion (q[9]), then undo the
    // XOR (q[8]=1) or XNOR (q[8]=0) chain.
    always_comb begin
        q_inv       = sr_q[9] ? ~sr_q[7:0] : sr_q[7:0];
        dec_data    = 8'h00;
        dec_data[0] = q_inv[0];
        for (int i = 1; i < 8; i++) begin
            dec_data[i] = sr_q[8] ? (q_inv[i] ^ q_inv[i-1])
                                  : ~(q_inv[i] ^ q_inv[i-1]);
        end
    end

    always_comb begin
        // New bit enters at the top so sr[0] is always the oldest bit.
        sr_d        = {in_tmds, sr_q[9:1]};
        phase_d     = boundary ? 4'd0 : (phase_q + 4'd1);
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        timeout_d   = timeout_q;
        out_valid_d = 1'b0;
        out_de_d    = out_de_q;
        out_data_d  = out_data_q;
        out_c_d     = out_c_q;

        case (state_q)
            SEARCH: begin
                timeout_d   = '0;
                match_cnt_d = '0;
                // Any token seen here defines the word phase: the next
                // complete word lands in sr ten cycles later (phase 9).
                if (is_token) begin
                    phase_d     = 4'd0;
                    match_cnt_d = MATCH_W'(1);
                    state_d     = (LOCK_COUNT <= 1) ? LOCKED : CONFIRM;
                end
            end

            CONFIRM: begin
                if (boundary) begin
                    if (is_token) begin
                        match_cnt_d = match_inc;
                        if (match_inc >= LOCK_COUNT_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    if (is_token) begin
                        // A token always clears the timeout, even on the
                        // word that would otherwise have expired it.
                        timeout_d   = '0;
                        out_valid_d = 1'b1;
                        out_de_d    = 1'b0;
                        out_data_d  = 8'h00;
                        out_c_d     = token_c;
                    end else if (timeout_inc >= TIMEOUT_WORDS_C) begin
                        // The expiring word is dropped, not emitted.
                        timeout_d   = '0;
                        match_cnt_d = '0;
                        state_d     = SEARCH;
                    end else begin
                        timeout_d   = timeout_inc;
                        out_valid_d = 1'b1;
                        out_de_d    = 1'b1;
                        out_data_d  = dec_data;
                    end
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase

        out_locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge tmds_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= SEARCH;
            sr_q         <= '0;
            phase_q      <= '0;
            match_cnt_q  <= '0;
            timeout_q    <= '0;
            out_valid_q  <= 1'b0;
            out_de_q     <= 1'b0;
            out_data_q   <= 8'h00;
            out_c_q      <= 2'b00;
            out_locked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            phase_q      <= phase_d;
            match_cnt_q  <= match_cnt_d;
            timeout_q    <= timeout_d;
            out_valid_q  <= out_valid_d;
            out_de_q     <= out_de_d;
            out_data_q   <= out_data_d;
            out_c_q      <= out_c_d;
            out_locked_q <= out_locked_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_de     = out_de_q;
    assign out_data   = out_data_q;
    assign out_c      = out_c_q;
    assign out_locked = out_locked_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_rx_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_rx_channel
//  Purpose  : Self-checking bench for tmds_rx_channel. Drives serial TMDS
//             words LSB first and compares decoded strobes, lock and timeout
//             timing against hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_rx_channel;

    localparam int NV = 11;

    logic       tmds_clk = 1'b0;
    logic       resetn   = 1'b0;
    logic       in_tmds  = 1'b0;
    logic       out_valid;
    logic       out_de;
    logic [7:0] out_data;
    logic [1:0] out_c;
    logic       out_locked;

    tmds_rx_channel #(
        .LOCK_COUNT    (8),
        .TIMEOUT_WORDS (16)
    ) u_dut (
        .tmds_clk   (tmds_clk),
        .resetn     (resetn),
        .in_tmds    (in_tmds),
        .out_valid  (out_valid),
        .out_de     (out_de),
        .out_data   (out_data),
        .out_c      (out_c),
        .out_locked (out_locked)
    );

    always #5 tmds_clk = ~tmds_clk;

    typedef struct {
        int         cyc;
        logic       de;
        logic [7:0] data;
        logic [1:0] c;
    } strobe_t;

    typedef struct {
        logic [9:0] word;
        logic       exp_de;
        logic [7:0] exp_data;
        logic [1:0] exp_c;
    } vec_t;

    vec_t    vecs [NV];
    strobe_t sq [$];
    int      cyc         = 0;
    int      rise_cyc    = -1;
    int      fall_cyc    = -1;
    logic    locked_prev = 1'b0;
    int      n_checks    = 0;
    int      n_fail      = 0;

    always @(posedge tmds_clk) cyc <= cyc + 1;

    // Strobe / lock-edge recorder, sampled on the falling edge.
    always @(negedge tmds_clk) begin
        if (out_valid === 1'b1) begin
            sq.push_back('{cyc: cyc, de: out_de, data: out_data, c: out_c});
        end
        if (out_locked === 1'b1 && locked_prev == 1'b0) rise_cyc = cyc;
        if (out_locked !== 1'b1 && locked_prev == 1'b1) fall_cyc = cyc;
        locked_prev = (out_locked === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit i of w is captured on the rising edge after the negedge it is
    // driven on; last_cyc is the cycle count at the final bit's negedge, so
    // a strobe or lock edge for this word is seen at last_cyc + 2.
    task automatic send_word(input logic [9:0] w, output int last_cyc);
        for (int i = 0; i < 10; i++) begin
            @(negedge tmds_clk);
            in_tmds = w[i];
        end
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge tmds_clk);
        #1;
    endtask

    task automatic clear_log();
        sq.delete();
        rise_cyc = -1;
        fall_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge tmds_clk);
        resetn  = 1'b0;
        in_tmds = 1'b0;
        repeat (3) @(negedge tmds_clk);
        resetn = 1'b1;
        #1;
        clear_log();
    endtask

    task automatic lock_up(output int last_cyc);
        for (int k = 0; k < 8; k++) send_word(10'h354, last_cyc);
    endtask

    initial begin
        int       l8;
        int       lw;
        int       dummy;
        int       lastc [NV];
        int       ndata;
        logic [2:0] pad;

        // word, de, data, c  (c on data words is the last token's value)
        vecs[0]  = '{10'h354, 1'b0, 8'h00, 2'b00};
        vecs[1]  = '{10'h100, 1'b1, 8'h00, 2'b00};
        vecs[2]  = '{10'h2FF, 1'b1, 8'hFE, 2'b00};
        vecs[3]  = '{10'h0AB, 1'b0, 8'h00, 2'b01};
        vecs[4]  = '{10'h1FF, 1'b1, 8'h01, 2'b01};
        vecs[5]  = '{10'h154, 1'b0, 8'h00, 2'b10};
        vecs[6]  = '{10'h0FF, 1'b1, 8'hFF, 2'b10};
        vecs[7]  = '{10'h2AB, 1'b0, 8'h00, 2'b11};
        vecs[8]  = '{10'h155, 1'b1, 8'hFF, 2'b11};
        vecs[9]  = '{10'h2AA, 1'b1, 8'h01, 2'b11};
        vecs[10] = '{10'h3FF, 1'b1, 8'h00, 2'b11};

        // ---- Reset with a random stream ----
        resetn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge tmds_clk);
            in_tmds = 1'($urandom_range(0, 1));
        end
        #1;
        check("rst_valid",  out_valid,  0);
        check("rst_de",     out_de,     0);
        check("rst_data",   out_data,   0);
        check("rst_c",      out_c,      0);
        check("rst_locked", out_locked, 0);

        // ---- Release, no tokens: stays unlocked ----
        @(negedge tmds_clk);
        resetn  = 1'b1;
        in_tmds = 1'b0;
        idle(20);
        check("idle_locked",  out_locked, 0);
        check("idle_strobes", sq.size(), 0);
        clear_log();

        // ---- Lock after an odd lead-in, then table of decoded words ----
        pad = 3'b101;
        for (int i = 0; i < 3; i++) begin
            @(negedge tmds_clk);
            in_tmds = pad[i];
        end
        lock_up(l8);
        for (int i = 0; i < NV; i++) send_word(vecs[i].word, lastc[i]);
        send_word(10'h354, dummy);
        send_word(10'h354, dummy);
        idle(1);
        check("lock_rise_cyc", rise_cyc, l8 + 2);
        for (int i = 0; i < NV; i++) begin
            if (i < sq.size()) begin
                check($sformatf("vec%0d_cyc",  i), sq[i].cyc,  lastc[i] + 2);
                check($sformatf("vec%0d_de",   i), sq[i].de,   vecs[i].exp_de);
                check($sformatf("vec%0d_data", i), sq[i].data, vecs[i].exp_data);
                check($sformatf("vec%0d_c",    i), sq[i].c,    vecs[i].exp_c);
            end else begin
                check($sformatf("vec%0d_present", i), sq.size(), i + 1);
            end
        end

        // ---- Aborted confirm: 4 tokens then a data word ----
        do_reset();
        for (int k = 0; k < 4; k++) send_word(10'h154, dummy);
        send_word(10'h100, dummy);
        for (int k = 0; k < 3; k++) send_word(10'h000, dummy);
        idle(2);
        check("abort_rise",    rise_cyc,   -1);
        check("abort_locked",  out_locked, 0);
        check("abort_strobes", sq.size(),  0);

        // ---- Timeout after 16 consecutive data words ----
        do_reset();
        lock_up(l8);
        send_word(10'h354, dummy);
        for (int k = 0; k < 16; k++) send_word(10'h100, lw);
        for (int k = 0; k < 3; k++) send_word(10'h000, dummy);
        idle(2);
        check("to_rise_cyc", rise_cyc, l8 + 2);
        check("to_strobes",  sq.size(), 16);
        ndata = 0;
        foreach (sq[i]) if (sq[i].de === 1'b1) ndata++;
        check("to_data_strobes", ndata, 15);
        check("to_fall_cyc", fall_cyc, lw + 2);
        check("to_locked_end", out_locked, 0);

        // ---- Reset in the middle of LOCKED ----
        do_reset();
        lock_up(l8);
        send_word(10'h2AB, dummy);
        @(posedge tmds_clk);
        @(posedge tmds_clk);
        #2;
        check("mid_pre_locked", out_locked, 1);
        check("mid_pre_c",      out_c,      2'b11);
        resetn = 1'b0;
        #1;
        check("mid_rst_locked", out_locked, 0);
        check("mid_rst_c",      out_c,      0);
        check("mid_rst_de",     out_de,     0);
        check("mid_rst_valid",  out_valid,  0);
        repeat (3) @(negedge tmds_clk);
        resetn  = 1'b1;
        in_tmds = 1'b0;
        #1;
        clear_log();
        lock_up(l8);
        idle(3);
        check("relock_rise_cyc", rise_cyc, l8 + 2);
        check("relock_strobes",  sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
